// File: rtl/mania_pixel_gen_if.sv
// Pixel-request bus between the VGA sync controller (master) and a pixel source (slave).
// The controller drives the pixel address and request strobe, and the source returns the colour.
interface mania_pixel_gen_if;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [11:0] d_in;

  modport master (output row_addr, output col_addr, output rdn, input d_in);
  modport slave  (input row_addr, input col_addr, input rdn, output d_in);
endinterface

// File: rtl/mania_pixel_gen.sv
// Pixel source for the 4-lane rhythm game: owns falling notes, key judging and
// score/miss counters, and answers each pixel request with a registered 12-bit colour.
module mania_pixel_gen #(
  parameter int LANE_X0      = 160,
  parameter int JUDGE_Y      = 440,
  parameter int HIT_WIN      = 16,
  parameter int SPEED        = 4,
  parameter int SPAWN_PERIOD = 30
) (
  input  logic             vga_clk,
  input  logic             clrn,
  mania_pixel_gen_if.slave pix,
  input  logic [3:0]       key,
  output logic [9:0]       score,
  output logic [9:0]       miss
);
  localparam logic [9:0] X0         = 10'(LANE_X0);
  localparam logic [9:0] X_END      = 10'(LANE_X0 + 320);
  localparam logic [9:0] JY         = 10'(JUDGE_Y);
  localparam logic [9:0] WIN_LO     = 10'(JUDGE_Y - HIT_WIN);
  localparam logic [9:0] WIN_HI     = 10'(JUDGE_Y + HIT_WIN);
  localparam logic [9:0] STEP       = 10'(SPEED);
  localparam logic [9:0] Y_LIMIT    = 10'd480;
  localparam logic [9:0] NOTE_H     = 10'd16;
  localparam logic [9:0] HALF_H     = 10'd8;
  localparam logic [9:0] LANE_W     = 10'd80;
  localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_PERIOD - 1);

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [2:0] n);
    logic [10:0] sum;
    sum = {1'b0, a} + {8'd0, n};
    return (sum > 11'd1023) ? 10'h3FF : sum[9:0];
  endfunction

  logic [3:0]  key_meta_r, key_sync_r, key_prev_r;
  logic [3:0]  act_r, act_nxt_s;
  logic [9:0]  y_r [4];
  logic [9:0]  y_nxt_s [4];
  logic [9:0]  y_mv_s [4];
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [7:0]  lfsr_r, lfsr_nxt_s;
  logic [9:0]  score_r, miss_r;
  logic [11:0] d_in_r, pix_nxt_s;
  logic [3:0]  press_s, hit_s;
  logic [2:0]  hit_cnt_s, miss_cnt_s;
  logic        tick_s;
  logic [9:0]  row_s;
  logic [9:0]  lane_lo_s [5];
  logic        note_px_s, judge_px_s, held_px_s, bound_px_s;

  assign press_s = key_sync_r & ~key_prev_r;
  assign tick_s  = ~pix.rdn && (pix.row_addr == 9'd0) && (pix.col_addr == 10'd0);
  assign row_s   = {1'b0, pix.row_addr};
  assign score   = score_r;
  assign miss    = miss_r;
  assign pix.d_in = d_in_r;

  // Hits are judged every cycle; a tick then moves the surviving notes and finally tries a spawn.
  always_comb begin
    act_nxt_s  = act_r;
    y_nxt_s    = y_r;
    cnt_nxt_s  = cnt_r;
    lfsr_nxt_s = lfsr_r;
    hit_cnt_s  = 3'd0;
    miss_cnt_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      y_mv_s[i] = y_r[i] + STEP;
      hit_s[i]  = press_s[i] && act_r[i] &&
                  (y_r[i] + HALF_H >= WIN_LO) && (y_r[i] + HALF_H <= WIN_HI);
      if (hit_s[i]) begin
        act_nxt_s[i] = 1'b0;
        hit_cnt_s    = hit_cnt_s + 3'd1;
      end else if (tick_s && act_r[i]) begin
        y_nxt_s[i] = y_mv_s[i];
        if (y_mv_s[i] >= Y_LIMIT) begin
          act_nxt_s[i] = 1'b0;
          miss_cnt_s   = miss_cnt_s + 3'd1;
        end else begin
          act_nxt_s[i] = 1'b1;
        end
      end else begin
        y_nxt_s[i] = y_r[i];
      end
    end
    if (tick_s) begin
      if (cnt_r == SPAWN_LAST) begin
        cnt_nxt_s  = 8'd0;
        lfsr_nxt_s = lfsr_next(lfsr_r);
        if (!act_nxt_s[lfsr_r[1:0]]) begin
          act_nxt_s[lfsr_r[1:0]] = 1'b1;
          y_nxt_s[lfsr_r[1:0]]   = 10'd0;
        end else begin
          cnt_nxt_s = 8'd0;
        end
      end else begin
        cnt_nxt_s = cnt_r + 8'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Colour lookup for the requested pixel, in priority order note > judge > held lane > boundary.
  always_comb begin
    note_px_s  = 1'b0;
    held_px_s  = 1'b0;
    bound_px_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lane_lo_s[i] = X0 + LANE_W * 10'(i);
      if (pix.col_addr == lane_lo_s[i]) bound_px_s = 1'b1;
      else bound_px_s = bound_px_s;
    end
    for (int i = 0; i < 4; i++) begin
      if ((pix.col_addr >= lane_lo_s[i]) && (pix.col_addr < lane_lo_s[i] + LANE_W)) begin
        if (act_r[i] && (row_s >= y_r[i]) && (row_s < y_r[i] + NOTE_H)) note_px_s = 1'b1;
        else note_px_s = note_px_s;
        if (key_sync_r[i]) held_px_s = 1'b1;
        else held_px_s = held_px_s;
      end else begin
        note_px_s = note_px_s;
      end
    end
    judge_px_s = (row_s >= JY) && (row_s <= JY + 10'd1) &&
                 (pix.col_addr >= X0) && (pix.col_addr < X_END);
    if (pix.rdn)       pix_nxt_s = 12'h000;
    else if (note_px_s)  pix_nxt_s = 12'hFFF;
    else if (judge_px_s) pix_nxt_s = 12'h00F;
    else if (held_px_s)  pix_nxt_s = 12'h333;
    else if (bound_px_s) pix_nxt_s = 12'h888;
    else                 pix_nxt_s = 12'h000;
  end

  // Two-flop synchroniser for the asynchronous keys plus one flop of history for edge detection.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      key_meta_r <= 4'd0;
      key_sync_r <= 4'd0;
      key_prev_r <= 4'd0;
    end else begin
      key_meta_r <= key;
      key_sync_r <= key_meta_r;
      key_prev_r <= key_sync_r;
    end
  end

  // Note slots, spawn counter and LFSR.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      act_r  <= 4'd0;
      cnt_r  <= 8'd0;
      lfsr_r <= 8'hA5;
      for (int i = 0; i < 4; i++) y_r[i] <= 10'd0;
    end else begin
      act_r  <= act_nxt_s;
      cnt_r  <= cnt_nxt_s;
      lfsr_r <= lfsr_nxt_s;
      for (int i = 0; i < 4; i++) y_r[i] <= y_nxt_s[i];
    end
  end

  // Registered colour and saturating counters.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      d_in_r  <= 12'h000;
      score_r <= 10'd0;
      miss_r  <= 10'd0;
    end else begin
      d_in_r  <= pix_nxt_s;
      score_r <= sat_add(score_r, hit_cnt_s);
      miss_r  <= sat_add(miss_r, miss_cnt_s);
    end
  end
endmodule

// File: tb/tb_mania_pixel_gen.sv
// Self-checking bench for mania_pixel_gen: fixed render table, directed game sequences and
// random traffic, all compared against a behavioural model of the game rules.
module tb_mania_pixel_gen;
  logic       vga_clk = 1'b0;
  logic       clrn;
  logic [3:0] key;
  logic [9:0] score, miss;

  mania_pixel_gen_if pif();

  mania_pixel_gen dut (
    .vga_clk(vga_clk), .clrn(clrn), .pix(pif), .key(key), .score(score), .miss(miss)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  bit         m_act [4];
  int         m_y [4];
  int         m_score, m_miss, m_cnt, m_hit_ev;
  logic [7:0] m_lfsr;
  logic [3:0] m_k1, m_k2, m_k3;
  logic [11:0] m_pix;

  typedef struct {
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_act[i] = 1'b0; m_y[i] = 0; end
    m_score = 0; m_miss = 0; m_cnt = 0; m_lfsr = 8'hA5;
    m_k1 = 4'd0; m_k2 = 4'd0; m_k3 = 4'd0; m_pix = 12'h000;
  endtask

  function automatic logic [11:0] model_pix(input int r, input int c, input bit rd,
                                            input logic [3:0] held);
    int lo;
    if (rd) return 12'h000;
    for (int i = 0; i < 4; i++) begin
      lo = 160 + 80 * i;
      if (c >= lo && c < lo + 80 && m_act[i] && r >= m_y[i] && r < m_y[i] + 16) return 12'hFFF;
    end
    if (r >= 440 && r <= 441 && c >= 160 && c < 480) return 12'h00F;
    for (int i = 0; i < 4; i++) begin
      lo = 160 + 80 * i;
      if (held[i] && c >= lo && c < lo + 80) return 12'h333;
    end
    for (int i = 0; i < 5; i++) if (c == 160 + 80 * i) return 12'h888;
    return 12'h000;
  endfunction

  task automatic model_step(input logic [8:0] r, input logic [9:0] c, input logic rd,
                            input logic [3:0] k);
    logic [3:0] press;
    bit tick;
    int l;
    m_pix = model_pix(int'(r), int'(c), rd, m_k2);
    press = m_k2 & ~m_k3;
    tick  = !rd && r == 9'd0 && c == 10'd0;
    for (int i = 0; i < 4; i++)
      if (press[i] && m_act[i] && m_y[i] + 8 >= 424 && m_y[i] + 8 <= 456) begin
        m_act[i] = 1'b0;
        m_score  = (m_score < 1023) ? m_score + 1 : 1023;
        m_hit_ev++;
      end
    if (tick) begin
      for (int i = 0; i < 4; i++)
        if (m_act[i]) begin
          m_y[i] += 4;
          if (m_y[i] >= 480) begin
            m_act[i] = 1'b0;
            m_miss   = (m_miss < 1023) ? m_miss + 1 : 1023;
          end
        end
      if (m_cnt == 29) begin
        m_cnt = 0;
        l = int'(m_lfsr[1:0]);
        if (!m_act[l]) begin m_act[l] = 1'b1; m_y[l] = 0; end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end else begin
        m_cnt++;
      end
    end
    m_k3 = m_k2; m_k2 = m_k1; m_k1 = k;
  endtask

  task automatic cyc(input logic [8:0] r, input logic [9:0] c, input logic rd, input logic [3:0] k);
    pif.row_addr = r; pif.col_addr = c; pif.rdn = rd; key = k;
    @(posedge vga_clk);
    model_step(r, c, rd, k);
    #1;
    chk("d_in", pif.d_in, m_pix);
    chk("score", {2'b00, score}, 12'(m_score));
    chk("miss", {2'b00, miss}, 12'(m_miss));
  endtask

  task automatic spawn_check(input string tag);
    for (int t = 1; t <= 30; t++) begin
      cyc(9'd0, 10'd0, 1'b0, 4'd0);
      cyc(9'd5, 10'd250, 1'b0, 4'd0);
      if (t == 29) chk({tag, "_no_note_29"}, pif.d_in, 12'h000);
      if (t == 30) chk({tag, "_spawn_lane1"}, pif.d_in, 12'hFFF);
    end
  endtask

  int         found, yold, s0, e0;
  bit         sat_done;
  logic [3:0] kk, rk;
  logic [8:0] rr;
  logic [9:0] cc;
  logic       rd;
  int         ln;

  initial begin
    tbl[0]  = '{9'd100, 10'd330, 1'b0, 12'h333};
    tbl[1]  = '{9'd440, 10'd330, 1'b0, 12'h00F};
    tbl[2]  = '{9'd100, 10'd160, 1'b0, 12'h888};
    tbl[3]  = '{9'd100, 10'd100, 1'b0, 12'h000};
    tbl[4]  = '{9'd100, 10'd330, 1'b1, 12'h000};
    tbl[5]  = '{9'd441, 10'd160, 1'b0, 12'h00F};
    tbl[6]  = '{9'd442, 10'd330, 1'b0, 12'h333};
    tbl[7]  = '{9'd100, 10'd480, 1'b0, 12'h888};
    tbl[8]  = '{9'd100, 10'd479, 1'b0, 12'h000};
    tbl[9]  = '{9'd439, 10'd200, 1'b0, 12'h000};
    tbl[10] = '{9'd440, 10'd159, 1'b0, 12'h000};
    tbl[11] = '{9'd100, 10'd320, 1'b0, 12'h333};

    // reset with keys toggling
    clrn = 1'b0; key = 4'd0; pif.rdn = 1'b1; pif.row_addr = 9'd0; pif.col_addr = 10'd0;
    model_reset(); m_hit_ev = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge vga_clk); #1;
      key = 4'($urandom);
      chk("rst_d_in", pif.d_in, 12'h000);
      chk("rst_score", {2'b00, score}, 12'd0);
      chk("rst_miss", {2'b00, miss}, 12'd0);
    end
    key = 4'd0;
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(9'd100, 10'd330, 1'b1, 4'd0);
    chk("rdn_high_black", pif.d_in, 12'h000);

    // render priority table with key[2] held and no notes
    for (int i = 0; i < 3; i++) cyc(9'd100, 10'd330, 1'b1, 4'b0100);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].row, tbl[i].col, tbl[i].rdn, 4'b0100);
      chk($sformatf("tbl%0d", i), pif.d_in, tbl[i].exp);
    end
    for (int i = 0; i < 3; i++) cyc(9'd100, 10'd330, 1'b1, 4'd0);

    spawn_check("first");

    // lane 1 note falls to y=416, then hit and a repeated press
    for (int i = 0; i < 104; i++) cyc(9'd0, 10'd0, 1'b0, 4'd0);
    cyc(9'd421, 10'd250, 1'b0, 4'd0);
    chk("note_at_416", pif.d_in, 12'hFFF);
    for (int i = 0; i < 3; i++) cyc(9'd200, 10'd250, 1'b0, 4'b0010);
    chk("hit_score", {2'b00, score}, 12'd1);
    for (int i = 0; i < 2; i++) cyc(9'd200, 10'd250, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(9'd200, 10'd250, 1'b0, 4'b0010);
    chk("second_press", {2'b00, score}, 12'd1);
    for (int i = 0; i < 2; i++) cyc(9'd200, 10'd250, 1'b0, 4'd0);
    cyc(9'd421, 10'd250, 1'b0, 4'd0);
    chk("hit_cleared", pif.d_in, 12'h000);

    // press landing on a frame tick
    found = -1;
    for (int t = 0; t < 200 && found < 0; t++) begin
      cyc(9'd0, 10'd0, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++)
        if (found < 0 && m_act[i] && m_y[i] >= 416 && m_y[i] <= 444) found = i;
    end
    chk("tick_hit_found", {11'd0, found >= 0}, 12'd1);
    if (found >= 0) begin
      kk = 4'd0; kk[found] = 1'b1; yold = m_y[found]; s0 = m_score;
      cyc(9'd200, 10'd250, 1'b0, kk);
      cyc(9'd200, 10'd250, 1'b0, kk);
      cyc(9'd0, 10'd0, 1'b0, kk);
      chk("tick_hit_score", {2'b00, score}, 12'(s0 + 1));
      cyc(9'(yold + 4), 10'(165 + 80 * found), 1'b0, 4'd0);
      chk("tick_hit_no_move", {11'd0, pif.d_in == 12'hFFF}, 12'd0);
    end

    // leave a note to fall off the bottom
    for (int t = 0; t < 400 && m_miss == 0; t++) cyc(9'd0, 10'd0, 1'b0, 4'd0);
    chk("miss_one", {2'b00, miss}, 12'd1);

    // random traffic
    rk = 4'd0;
    for (int n = 0; n < 1500; n++) begin
      ln = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        rr = 9'd0; cc = 10'd0; rd = 1'b0;
      end else begin
        rd = ($urandom_range(0, 4) == 0);
        if (m_act[ln] && $urandom_range(0, 1) == 1) begin
          rr = 9'(m_y[ln] + int'($urandom_range(0, 17)));
          cc = 10'(160 + 80 * ln + int'($urandom_range(0, 79)));
        end else begin
          rr = 9'($urandom_range(0, 479));
          cc = 10'($urandom_range(0, 639));
        end
      end
      if ($urandom_range(0, 2) == 0) rk = 4'($urandom);
      cyc(rr, cc, rd, rk);
    end

    // drive score to saturation: tick every cycle, all keys toggling
    sat_done = 1'b0; e0 = -1;
    for (int n = 0; n < 75000 && !sat_done; n++) begin
      cyc(9'd0, 10'd0, 1'b0, (n % 2 == 1) ? 4'hF : 4'h0);
      if (e0 < 0 && m_score == 1023) e0 = m_hit_ev;
      else if (e0 >= 0 && m_hit_ev > e0) sat_done = 1'b1;
    end
    chk("sat_reached", {11'd0, sat_done}, 12'd1);
    chk("score_sat", {2'b00, score}, 12'd1023);

    // reset in the middle of a frame
    pif.row_addr = 9'd200; pif.col_addr = 10'd300; pif.rdn = 1'b0; key = 4'hF;
    @(negedge vga_clk); #2;
    clrn = 1'b0; #1;
    chk("mid_rst_d_in", pif.d_in, 12'h000);
    chk("mid_rst_score", {2'b00, score}, 12'd0);
    chk("mid_rst_miss", {2'b00, miss}, 12'd0);
    model_reset();
    key = 4'd0;
    @(negedge vga_clk);
    clrn = 1'b1;
    spawn_check("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mania_pixel_gen.md
Name: mania_pixel_gen

Overview:
- Pixel source for the 4-key rhythm-game VGA path; sits on the far side of the VGA sync controller's pixel-request interface.
- Takes the controller's row_addr, col_addr and rdn, and returns the 12-bit colour on d_in.
- Owns the game state: four lanes of falling notes, key hit/miss judging, score and miss counters.
- Frame timing comes from the pixel-request stream itself; it needs no separate sync input.

Parameters:
- LANE_X0, 160: first column of lane 0. Lanes are 80 px wide, lane i spans cols LANE_X0+80i .. LANE_X0+80i+79.
- JUDGE_Y, 440: first row of the 2-row judge line.
- HIT_WIN, 16: half-width of the hit window in rows.
- SPEED, 4: note fall in px per frame.
- SPAWN_PERIOD, 30: frames between spawn attempts.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- clrn  in  1  asynchronous active-low reset.
- row_addr  in  9  pixel row (0..479 visible).
- col_addr  in  10  pixel column (0..639 visible).
- rdn  in  1  active-low pixel request; 0 = visible pixel.
- key  in  4  raw lane keys, active-high, asynchronous to vga_clk.
- d_in  out  12  pixel colour: [3:0] red, [7:4] green, [11:8] blue.
- score  out  10  hit count, saturating.
- miss  out  10  miss count, saturating.

Behaviour:
- Reset, asynchronous on clrn=0:
  - d_in=0, score=0, miss=0.
  - All note slots inactive, all y=0.
  - Spawn counter=0, LFSR=8'hA5.
  - Key synchronisers and edge registers = 0.
- Keys:
  - Each key passes through a 2-flop synchroniser.
  - A press is a rising edge on the synchronised signal; it is a 1-cycle pulse, 3 cycles after the raw edge.
- Frame tick: 1-cycle pulse in the cycle where rdn=0, row_addr=0 and col_addr=0.
- Note store: one slot per lane, each holding an active bit and a 10-bit top-edge y. Note height is 16 rows.
- Hit judging, every cycle, per lane:
  - A hit needs a press, an active note, and JUDGE_Y-HIT_WIN <= y+8 <= JUDGE_Y+HIT_WIN (defaults: y in 416..448).
  - On a hit: the note goes inactive and score increments, saturating at 1023.
  - A press with no note in the window has no effect.
- Frame-tick processing, per lane, in this priority order:
  1. Hit in the same cycle: the hit wins. The note clears and does not move.
  2. Otherwise, an active note moves: y <= y+SPEED.
  3. If the new y >= 480, the note clears and miss increments, saturating at 1023.
- Spawn, on frame ticks:
  - If the counter == SPAWN_PERIOD-1, the counter goes to 0 and a spawn is attempted. Otherwise the counter increments.
  - The attempt targets lane = LFSR[1:0].
  - If that lane's slot is free after this tick's hit/miss processing, the slot is set active with y=0 and does not move this tick. If the lane is occupied, the spawn is dropped.
  - The LFSR advances only on spawn attempts, taken or dropped. It is an 8-bit Fibonacci LFSR: polynomial x^8+x^6+x^5+x^4+1, shifted left, feedback = b7^b5^b4^b3 into b0.
- Rendering:
  - d_in is registered, with 1 vga_clk latency from the address/rdn inputs.
  - rdn=1 gives 12'h000.
  - Otherwise the first match wins:
    1. Active note covering the pixel (lane cols, y <= row < y+16): 12'hFFF.
    2. Rows JUDGE_Y..JUDGE_Y+1 inside the lane area: 12'h00F.
    3. Lane whose synchronised key is held: 12'h333.
    4. Lane boundary column (LANE_X0+80i, i=0..4): 12'h888.
    5. Background: 12'h000.
- Arithmetic: note y and all comparisons are 10-bit unsigned; nothing wraps because notes clear at y >= 480.
- Reset mid-frame: everything returns to reset values immediately. Counting restarts at the next frame tick.

Test Plan:
- Reset check: assert clrn=0 with keys toggling -> d_in=0, score=0, miss=0, all slots inactive. Release, drive rdn=1 -> d_in stays 000.
- First spawn: 29 frame ticks -> no notes. The 30th tick -> lane 1 (seed A5, bits[1:0]=01) active at y=0. Pixel (row 5, col 250) -> d_in=FFF one cycle later.
- Render priority: with no notes, hold key[2] -> (row 100, col 330)=333; (row 440, col 330)=00F; (row 100, col 160)=888; (row 100, col 100)=000.
- Hit: lane 1 note advanced 104 ticks to y=416; pulse key[1] -> slot clears, score=1. A second press -> score stays 1. A press coinciding with a frame tick -> hit wins, no move.
- Miss: leave the note for 120 ticks after spawn (y reaches 480) -> slot clears, miss=1.
- Saturation and reset: force 1023 hits -> score holds 1023 on the next hit. Pull clrn low mid-frame -> all state reset. The next spawn occurs 30 ticks later in lane 1 again.
